// File: rtl/parity_frame_rx.sv
// Bit-serial to 6-bit frame receiver for the parity checker stage.
// It keeps one output frame buffer, a saturating parity-error count and a sticky overrun flag.
module parity_frame_rx #(
  parameter bit ODD_PARITY = 1'b0,
  parameter int ERR_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sync,
  input  logic             sin,
  input  logic             sin_valid,
  input  logic             clr_stat,
  output logic [5:0]       frame_out,
  output logic [1:0]       parity_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ERR_W-1:0] err_count,
  output logic             overrun
);

  // Output handshake: a frame transfers on any edge where out_valid && out_ready.
  // While out_valid=1 and out_ready=0, frame_out and parity_out are held stable.
  // The buffer can be drained and refilled on the same edge.

  logic [2:0] cnt;
  logic [4:0] partial;

  logic       take;
  logic       complete;
  logic [5:0] word;
  logic       p;
  logic       buf_free;
  logic       err_hit;

  always_comb begin
    take     = sin_valid && !sync;
    complete = take && (cnt == 3'd5);
    word     = {sin, partial};
    p        = ^word;
    buf_free = !out_valid || out_ready;
    err_hit  = complete && (p != ODD_PARITY);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= '0;
      partial    <= '0;
      frame_out  <= '0;
      parity_out <= '0;
      out_valid  <= 1'b0;
      err_count  <= '0;
      overrun    <= 1'b0;
    end else begin
      if (sync) begin
        cnt     <= '0;
        partial <= '0;
      end else if (sin_valid) begin
        if (cnt == 3'd5) begin
          cnt <= '0;
        end else begin
          partial[cnt] <= sin;
          cnt          <= cnt + 3'd1;
        end
      end

      if (complete && buf_free) begin
        frame_out  <= word;
        parity_out <= {~p, p};
        out_valid  <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end

      // Clear has priority over a same-edge error or overrun event.
      if (clr_stat) begin
        err_count <= '0;
        overrun   <= 1'b0;
      end else begin
        if (err_hit && (err_count != {ERR_W{1'b1}}))
          err_count <= err_count + 1'b1;
        if (complete && !buf_free)
          overrun <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_parity_frame_rx.sv
// Self-checking bench for parity_frame_rx: directed steps then random traffic,
// checked against a queue-based frame model; a second instance has a 2-bit error counter.
module tb_parity_frame_rx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, sync, sin, sin_valid, clr_stat, out_ready;
  logic [5:0] frame_a, frame_b;
  logic [1:0] par_a, par_b;
  logic       valid_a, valid_b, ovr_a, ovr_b;
  logic [7:0] err_a;
  logic [1:0] err_b;

  parity_frame_rx #(.ODD_PARITY(1'b0), .ERR_W(8)) dut_a (
    .clk(clk), .rst(rst), .sync(sync), .sin(sin), .sin_valid(sin_valid),
    .clr_stat(clr_stat), .frame_out(frame_a), .parity_out(par_a),
    .out_valid(valid_a), .out_ready(out_ready), .err_count(err_a), .overrun(ovr_a)
  );

  parity_frame_rx #(.ODD_PARITY(1'b0), .ERR_W(2)) dut_b (
    .clk(clk), .rst(rst), .sync(sync), .sin(sin), .sin_valid(sin_valid),
    .clr_stat(clr_stat), .frame_out(frame_b), .parity_out(par_b),
    .out_valid(valid_b), .out_ready(out_ready), .err_count(err_b), .overrun(ovr_b)
  );

  int tests = 0;
  int fails = 0;

  // Reference model: bits collect in a queue; a full queue becomes a frame.
  bit         bitq[$];
  logic [5:0] m_frame;
  logic [1:0] m_par;
  logic       m_valid, m_ovr;
  int         m_e8, m_e2;

  task automatic model_update();
    logic [5:0] w;
    logic       done, p, free;
    done = 1'b0;
    w    = '0;
    p    = 1'b0;
    if (rst) begin
      bitq.delete();
      m_frame = '0; m_par = '0; m_valid = 1'b0; m_ovr = 1'b0; m_e8 = 0; m_e2 = 0;
    end else begin
      if (sync) bitq.delete();
      else if (sin_valid) begin
        bitq.push_back(sin);
        if (bitq.size() == 6) begin
          for (int i = 0; i < 6; i++) w[i] = bitq[i];
          bitq.delete();
          done = 1'b1;
          p = ($countones(w) % 2) == 1;
        end
      end
      free = !m_valid || out_ready;
      if (done && free) begin
        m_frame = w; m_par = {~p, p}; m_valid = 1'b1;
      end else if (m_valid && out_ready) begin
        m_valid = 1'b0;
      end
      if (clr_stat) begin
        m_e8 = 0; m_e2 = 0; m_ovr = 1'b0;
      end else begin
        if (done && p != 1'b0) begin
          m_e8 = (m_e8 < 255) ? m_e8 + 1 : 255;
          m_e2 = (m_e2 < 3) ? m_e2 + 1 : 3;
        end
        if (done && !free) m_ovr = 1'b1;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_all();
    chk("frame_a", 32'(frame_a), 32'(m_frame));
    chk("par_a", 32'(par_a), 32'(m_par));
    chk("valid_a", 32'(valid_a), 32'(m_valid));
    chk("err_a", 32'(err_a), 32'(m_e8));
    chk("ovr_a", 32'(ovr_a), 32'(m_ovr));
    chk("frame_b", 32'(frame_b), 32'(m_frame));
    chk("valid_b", 32'(valid_b), 32'(m_valid));
    chk("err_b", 32'(err_b), 32'(m_e2));
    chk("ovr_b", 32'(ovr_b), 32'(m_ovr));
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
    check_all();
  endtask

  task automatic idle(input int n);
    sin_valid = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic send_bit(input logic b, input logic clr);
    sin = b; sin_valid = 1'b1; clr_stat = clr;
    tick();
    sin_valid = 1'b0; clr_stat = 1'b0;
  endtask

  task automatic send_frame(input logic [5:0] w, input int gap, input logic clr_last);
    for (int i = 0; i < 6; i++) begin
      send_bit(w[i], (i == 5) ? clr_last : 1'b0);
      if (i < 5 && gap > 0) idle(gap);
    end
  endtask

  initial begin
    rst = 1'b1; sync = 1'b0; sin = 1'b0; sin_valid = 1'b0; clr_stat = 1'b0; out_ready = 1'b1;
    tick();
    chk("rst_frame", 32'(frame_a), 32'h0);
    chk("rst_valid", 32'(valid_a), 32'h0);
    chk("rst_err", 32'(err_a), 32'h0);
    rst = 1'b0;

    // Frame 000111 back-to-back; out_valid must rise right after the sixth bit.
    send_frame(6'b000111, 0, 1'b0);
    chk("t1_valid", 32'(valid_a), 32'h1);
    chk("t1_frame", 32'(frame_a), 32'h07);
    chk("t1_par", 32'(par_a), 32'h1);
    chk("t1_err", 32'(err_a), 32'h1);
    idle(1);
    chk("t1_drain", 32'(valid_a), 32'h0);

    // Gapped bits
    send_frame(6'b000011, 3, 1'b0);
    chk("t2_frame", 32'(frame_a), 32'h03);
    chk("t2_par", 32'(par_a), 32'h2);
    chk("t2_err", 32'(err_a), 32'h1);
    idle(1);

    // Backpressure: second frame dropped but counted
    out_ready = 1'b0;
    send_frame(6'b001111, 0, 1'b0);
    chk("t3_par", 32'(par_a), 32'h2);
    send_frame(6'b011111, 0, 1'b0);
    chk("t3_frame", 32'(frame_a), 32'h0f);
    chk("t3_ovr", 32'(ovr_a), 32'h1);
    chk("t3_err", 32'(err_a), 32'h2);
    out_ready = 1'b1;
    idle(1);
    chk("t3_drain", 32'(valid_a), 32'h0);
    chk("t3_hold", 32'(frame_a), 32'h0f);

    // sync on the same edge as a valid bit drops it and the partial frame
    send_bit(1'b0, 1'b0); send_bit(1'b0, 1'b0); send_bit(1'b0, 1'b0);
    sync = 1'b1; sin = 1'b0; sin_valid = 1'b1;
    tick();
    sync = 1'b0; sin_valid = 1'b0;
    send_frame(6'b111111, 0, 1'b0);
    chk("t4_frame", 32'(frame_a), 32'h3f);
    chk("t4_par", 32'(par_a), 32'h2);
    idle(1);

    // Saturation of the 2-bit counter, then clear on an error edge
    for (int k = 0; k < 5; k++) send_frame(6'b000001, 0, 1'b0);
    chk("t5_sat", 32'(err_b), 32'h3);
    chk("t5_err8", 32'(err_a), 32'h7);
    send_frame(6'b000001, 0, 1'b1);
    chk("t5_clr_b", 32'(err_b), 32'h0);
    chk("t5_clr_a", 32'(err_a), 32'h0);
    chk("t5_clr_ovr", 32'(ovr_a), 32'h0);

    // Reset mid-frame with a held output
    out_ready = 1'b0;
    idle(1);
    send_frame(6'b010101, 0, 1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b0);
    chk("t6_held", 32'(valid_a), 32'h1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t6_frame0", 32'(frame_a), 32'h0);
    chk("t6_par0", 32'(par_a), 32'h0);
    chk("t6_valid0", 32'(valid_a), 32'h0);
    out_ready = 1'b1;
    send_frame(6'b000001, 0, 1'b0);
    chk("t6_frame", 32'(frame_a), 32'h01);
    chk("t6_par", 32'(par_a), 32'h1);

    // Random traffic
    for (int c = 0; c < 2000; c++) begin
      rst       = ($urandom_range(0, 199) == 0);
      sync      = ($urandom_range(0, 39) == 0);
      sin       = 1'($urandom_range(0, 1));
      sin_valid = ($urandom_range(0, 3) != 0);
      clr_stat  = ($urandom_range(0, 59) == 0);
      out_ready = ($urandom_range(0, 2) != 0);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/parity_frame_rx.md
Name: parity_frame_rx

Overview:
- Serial-to-parallel front end that feeds the 6-bit parity checker stage.
- Assembles 6-bit frames from a bit-serial stream, first bit received into bit 0.
- Computes the same parity flag pair the checker produces: bit1 = even parity, bit0 = odd parity.
- Holds each frame in a one-entry valid/ready output buffer; keeps a saturating parity-error counter and a sticky overrun flag.

Parameters:
- ODD_PARITY, 0: expected XOR of all 6 frame bits. A completed frame whose XOR differs is a parity error.
- ERR_W, 8: width of the parity-error counter.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- sync  in  1  frame realign; discards partial frame
- sin  in  1  serial data bit
- sin_valid  in  1  sin is sampled on this clock edge
- clr_stat  in  1  clears err_count and overrun
- frame_out  out  6  assembled frame, bit i = i-th bit received
- parity_out  out  2  {~p, p}, where p = XOR of frame_out bits
- out_valid  out  1  frame_out and parity_out are valid
- out_ready  in  1  consumer accepts the frame when out_valid=1
- err_count  out  ERR_W  number of parity-error frames, saturating
- overrun  out  1  sticky: a completed frame was dropped

Behaviour:
- Reset (rst=1 at clk edge): bit counter=0; partial shift register=0; frame_out=0; parity_out=0; out_valid=0; err_count=0; overrun=0. Reset overrides every other input, including mid-frame; any partial frame is lost.
- Bit counter runs 0..5.
- On an edge with sin_valid=1 and sync=0: store sin in partial[cnt].
  - If cnt<5: cnt increments.
  - If cnt=5: the frame completes on this edge and cnt returns to 0.
- sync=1: cnt<=0 and partial bits are discarded. sync wins over sin_valid on the same edge; that bit is dropped. sync does not touch the output buffer, err_count or overrun.
- The completed word is {sin, partial[4:0]}; p = XOR of its 6 bits.
- Output buffer is free when out_valid=0, or when out_valid=1 and out_ready=1 on the same edge (drain and refill in one cycle is allowed).
- Frame completes and buffer is free:
  - frame_out, parity_out={~p,p} and out_valid=1 are registered on the completing edge.
  - Latency: out_valid is high in the cycle after the sixth bit is sampled.
- Frame completes and buffer is not free:
  - New frame is dropped; overrun<=1.
  - Held frame_out and parity_out stay unchanged.
- Buffer drained (out_valid=1, out_ready=1) with no new frame completing: out_valid<=0. frame_out and parity_out keep their last values.
- While out_valid=1 and out_ready=0, frame_out and parity_out are stable.
- Throughput: at most one frame per 6 sin_valid cycles, so a consumer that is always ready never causes overrun.
- err_count:
  - Increments on every completed frame with p != ODD_PARITY, including dropped frames.
  - Saturates at 2^ERR_W-1; no wrap.
- clr_stat=1: err_count<=0 and overrun<=0. Clear wins over a simultaneous increment or overrun event on the same edge.
- sin_valid may have any gaps; partial bits are held indefinitely between valid bits.

Test Plan:
- Reset, then bits 1,1,1,0,0,0 with sin_valid continuous and out_ready=1 -> out_valid high exactly one cycle after the 6th bit; frame_out=6'b000111, parity_out=2'b01; err_count=1 (ODD_PARITY=0).
- Bits 1,1,0,0,0,0 with gaps of 3 idle cycles between bits -> frame_out=6'b000011, parity_out=2'b10; err_count unchanged.
- out_ready=0; send two frames, 6'b001111 then 6'b011111 -> first frame held, parity_out=2'b10; overrun=1; second frame dropped but counted, err_count+1; after out_ready=1, out_valid drops and frame_out still reads 6'b001111.
- Three bits, then sync pulsed with sin_valid=1 on the same edge, then 6 bits of 6'b111111 -> frame_out=6'b111111, parity_out=2'b10; none of the pre-sync bits appear.
- ERR_W=2: send 5 odd-parity frames -> err_count sticks at 3. clr_stat asserted on the edge of a further error frame -> err_count=0, overrun=0.
- rst asserted after 4 bits of a frame while out_valid=1 -> all outputs 0 next cycle; a following 6-bit frame 6'b000001 gives frame_out=6'b000001, parity_out=2'b01.
